// File: rtl/matrix_multiply.sv
// matrix_multiply
//   Sequential Q20.12 matrix multiplier, C = A x B, with every dimension up
//   to MAX_DIM. One signed MAC unit walks the products one per clock. A
//   result element is written one clock after its last product, so a run
//   takes 1 + rows*cols*(inner+1) clocks from the start-sampling edge.
//   The 64-bit accumulator is Q40.24. Each result is shifted back to Q20.12,
//   rounding toward -infinity, and saturated to 32 bits.
//
// Ports
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : level request, sampled only in IDLE
//   rows/inner/cols : dimensions, legal range 1..MAX_DIM
//   Ain, Bin        : row-major packed operands (slot s = bits [s*DATA_W +: DATA_W])
//   Cout            : row-major packed result; unwritten slots read 0
//   done            : result valid, held until start is low
//   err             : the last run had an illegal dimension
//   ovf             : at least one element saturated on the last run
module matrix_multiply #(
    parameter int DATA_W  = 32,
    parameter int FRAC    = 12,
    parameter int MAX_DIM = 6,
    localparam int BUS_W  = MAX_DIM*MAX_DIM*DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       rows,
    input  logic [2:0]       inner,
    input  logic [2:0]       cols,
    input  logic [BUS_W-1:0] Ain,
    input  logic [BUS_W-1:0] Bin,
    output logic [BUS_W-1:0] Cout,
    output logic             done,
    output logic             err,
    output logic             ovf
);
    localparam int ACC_W = 2*DATA_W;
    localparam logic [2:0] DMAX = 3'(MAX_DIM);
    localparam logic signed [ACC_W-1:0] SMAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SMIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, LOAD, MAC, WRITE, DONE} state_t;
    state_t state, state_nxt;

    logic [BUS_W-1:0]        a_r, b_r;
    logic [2:0]              rows_r, inner_r, cols_r;
    logic [2:0]              i_r, j_r, k_r;
    logic signed [ACC_W-1:0] acc, prod, shifted;
    logic signed [DATA_W-1:0] a_el, b_el, sat_val;
    logic [5:0]              a_slot, b_slot, c_slot;
    logic                    dims_bad, k_last, j_last, last_el, clamp_hi, clamp_lo;

    // Dimensions are judged on the values being latched in LOAD.
    assign dims_bad = (rows == 3'd0) || (rows > DMAX) ||
                      (inner == 3'd0) || (inner > DMAX) ||
                      (cols == 3'd0) || (cols > DMAX);

    assign a_slot = 6'(i_r) * 6'(inner_r) + 6'(k_r);
    assign b_slot = 6'(k_r) * 6'(cols_r) + 6'(j_r);
    assign c_slot = 6'(i_r) * 6'(cols_r) + 6'(j_r);

    assign a_el = a_r[a_slot*DATA_W +: DATA_W];
    assign b_el = b_r[b_slot*DATA_W +: DATA_W];
    assign prod = a_el * b_el;

    assign k_last  = (k_r == inner_r - 3'd1);
    assign j_last  = (j_r == cols_r - 3'd1);
    assign last_el = j_last && (i_r == rows_r - 3'd1);

    // Arithmetic shift floors; then clamp to the signed 32-bit range.
    assign shifted  = acc >>> FRAC;
    assign clamp_hi = shifted > SMAX;
    assign clamp_lo = shifted < SMIN;
    assign sat_val  = clamp_hi ? SMAX[DATA_W-1:0] :
                      clamp_lo ? SMIN[DATA_W-1:0] : shifted[DATA_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = dims_bad ? DONE : MAC;
            MAC:     if (k_last) state_nxt = WRITE;
            WRITE:   state_nxt = last_el ? DONE : MAC;
            DONE:    if (!start) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            rows_r  <= '0;
            inner_r <= '0;
            cols_r  <= '0;
            i_r     <= '0;
            j_r     <= '0;
            k_r     <= '0;
            acc     <= '0;
            Cout    <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    done <= 1'b0;
                    err  <= 1'b0;
                    ovf  <= 1'b0;
                end
                LOAD: begin
                    a_r     <= Ain;
                    b_r     <= Bin;
                    rows_r  <= rows;
                    inner_r <= inner;
                    cols_r  <= cols;
                    Cout    <= '0;
                    acc     <= '0;
                    i_r     <= '0;
                    j_r     <= '0;
                    k_r     <= '0;
                    if (dims_bad) begin
                        err  <= 1'b1;
                        done <= 1'b1;
                    end
                end
                MAC: begin
                    acc <= acc + prod;
                    if (!k_last) k_r <= k_r + 3'd1;
                end
                WRITE: begin
                    Cout[c_slot*DATA_W +: DATA_W] <= sat_val;
                    if (clamp_hi || clamp_lo) ovf <= 1'b1;
                    acc <= '0;
                    k_r <= '0;
                    if (j_last) begin
                        j_r <= '0;
                        i_r <= i_r + 3'd1;
                    end else begin
                        j_r <= j_r + 3'd1;
                    end
                    if (last_el) done <= 1'b1;
                end
                DONE: if (!start) done <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_multiply.sv
module tb_matrix_multiply;
    localparam int BUS_W = 1152;

    logic             clk, rst_n, start;
    logic [2:0]       rows, inner, cols;
    logic [BUS_W-1:0] Ain, Bin, Cout;
    logic             done, err, ovf;

    int passed = 0;
    int total  = 0;

    matrix_multiply dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .rows(rows), .inner(inner), .cols(cols),
        .Ain(Ain), .Bin(Bin), .Cout(Cout),
        .done(done), .err(err), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [BUS_W-1:0] put(input logic [BUS_W-1:0] b, input int s,
                                             input logic [31:0] v);
        b[s*32 +: 32] = v;
        return b;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Whole-bus compare reported through the first differing slot.
    task automatic chk_bus(input string tag, input logic [BUS_W-1:0] exp);
        int bad = 0;
        for (int s = 35; s >= 0; s--)
            if (Cout[s*32 +: 32] !== exp[s*32 +: 32]) bad = s;
        chk($sformatf("%s slot%0d", tag, bad), 64'(Cout[bad*32 +: 32]), 64'(exp[bad*32 +: 32]));
    endtask

    // Starts a run and counts edges after the start-sampling edge until done.
    task automatic run(input string tag, input logic [2:0] r, input logic [2:0] n,
                       input logic [2:0] c, input logic [BUS_W-1:0] a,
                       input logic [BUS_W-1:0] b, input int lat);
        int cnt = 0;
        @(negedge clk);
        rows = r; inner = n; cols = c; Ain = a; Bin = b; start = 1'b1;
        @(posedge clk);
        do begin
            @(posedge clk);
            cnt++;
            #1;
        end while (!done && cnt < 300);
        chk({tag, " latency"}, 64'(cnt), 64'(lat));
    endtask

    task automatic release_start(input string tag);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, " done falls"}, 64'(done), 64'd0);
    endtask

    logic [BUS_W-1:0] a, b, e;

    initial begin
        rst_n = 1'b0; start = 1'b0; rows = '0; inner = '0; cols = '0;
        Ain = '0; Bin = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_bus("reset Cout", '0);
        chk("reset flags", 64'({done, err, ovf}), 64'd0);
        rst_n = 1'b1;

        // 2x2x2 against identity, start held high through DONE
        a = '0; a = put(a, 0, 32'h1000); a = put(a, 1, 32'h2000);
        a = put(a, 2, 32'h3000); a = put(a, 3, 32'h4000);
        b = '0; b = put(b, 0, 32'h1000); b = put(b, 3, 32'h1000);
        run("2x2x2", 3'd2, 3'd2, 3'd2, a, b, 13);
        chk_bus("2x2x2 Cout", a);
        chk("2x2x2 err/ovf", 64'({err, ovf}), 64'd0);
        repeat (6) @(posedge clk);
        #1;
        chk("hold done", 64'(done), 64'd1);
        chk_bus("hold Cout", a);
        release_start("hold");
        repeat (2) @(posedge clk);
        #1;
        chk_bus("idle keeps Cout", a);

        // 2x3x2
        a = '0;
        for (int s = 0; s < 6; s++) a = put(a, s, 32'((s + 1) * 32'h1000));
        b = '0; b = put(b, 0, 32'h1000); b = put(b, 3, 32'h1000);
        b = put(b, 4, 32'h1000); b = put(b, 5, 32'h1000);
        e = '0; e = put(e, 0, 32'h4000); e = put(e, 1, 32'h5000);
        e = put(e, 2, 32'hA000); e = put(e, 3, 32'hB000);
        run("2x3x2", 3'd2, 3'd3, 3'd2, a, b, 17);
        chk_bus("2x3x2 Cout", e);
        release_start("2x3x2");

        // Rounding toward -infinity
        a = '0; a = put(a, 0, 32'h1);
        b = '0; b = put(b, 0, 32'hFFFFFFFF);
        run("rnd1", 3'd1, 3'd1, 3'd1, a, b, 3);
        chk("rnd1 C0", 64'(Cout[31:0]), 64'hFFFFFFFF);
        release_start("rnd1");
        a = put(a, 0, 32'hFFFFF800);
        b = put(b, 0, 32'h800);
        run("rnd2", 3'd1, 3'd1, 3'd1, a, b, 3);
        chk("rnd2 C0", 64'(Cout[31:0]), 64'hFFFFFC00);
        chk("rnd2 ovf", 64'(ovf), 64'd0);
        release_start("rnd2");

        // Saturation both ways
        a = put(a, 0, 32'h7FFFF000);
        b = put(b, 0, 32'h2000);
        run("sat+", 3'd1, 3'd1, 3'd1, a, b, 3);
        chk("sat+ C0", 64'(Cout[31:0]), 64'h7FFFFFFF);
        chk("sat+ ovf", 64'(ovf), 64'd1);
        release_start("sat+");
        a = put(a, 0, 32'h80000000);
        run("sat-", 3'd1, 3'd1, 3'd1, a, b, 3);
        chk("sat- C0", 64'(Cout[31:0]), 64'h80000000);
        chk("sat- ovf", 64'(ovf), 64'd1);
        release_start("sat-");

        // Illegal dimensions
        run("rows0", 3'd0, 3'd2, 3'd2, a, b, 1);
        chk("rows0 err/ovf", 64'({err, ovf}), 64'b10);
        chk_bus("rows0 Cout", '0);
        release_start("rows0");
        run("inner7", 3'd2, 3'd7, 3'd2, a, b, 1);
        chk("inner7 err", 64'(err), 64'd1);
        chk_bus("inner7 Cout", '0);
        release_start("inner7");

        // Legal run after an error clears err
        a = '0; a = put(a, 0, 32'h1000); a = put(a, 1, 32'h2000);
        a = put(a, 2, 32'h3000); a = put(a, 3, 32'h4000);
        b = '0; b = put(b, 0, 32'h1000); b = put(b, 3, 32'h1000);
        run("legal", 3'd2, 3'd2, 3'd2, a, b, 13);
        chk("legal err", 64'(err), 64'd0);
        chk_bus("legal Cout", a);
        release_start("legal");

        // Reset in the middle of a run, after the first element is written
        @(negedge clk);
        rows = 3'd2; inner = 3'd2; cols = 3'd2; Ain = a; Bin = b; start = 1'b1;
        @(posedge clk);
        repeat (6) @(posedge clk);
        #2;
        chk("pre-reset C0", 64'(Cout[31:0]), 64'h1000);
        rst_n = 1'b0;
        #1;
        chk_bus("abort Cout", '0);
        chk("abort flags", 64'({done, err, ovf}), 64'd0);
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        run("rerun", 3'd2, 3'd2, 3'd2, a, b, 13);
        chk_bus("rerun Cout", a);
        release_start("rerun");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
